// File: rtl/fix_stream_arbiter.sv
// fix_stream_arbiter: shares one fix_parser byte port between N_SRC FIX
// streams, one full message per grant, with checksum check and stall abort.
module fix_stream_arbiter #(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           src_valid_i,
  input  logic [8*N_SRC-1:0]         src_data_i,
  output logic [N_SRC-1:0]           src_ready_o,
  output logic [7:0]                 par_data_o,
  output logic                       par_valid_o,
  output logic                       par_sof_o,
  output logic                       par_eof_o,
  output logic [$clog2(N_SRC)-1:0]   par_src_o,
  output logic                       msg_done_o,
  output logic                       msg_chk_ok_o,
  output logic                       msg_abort_o,
  output logic                       busy_o
);

  localparam int SW = $clog2(N_SRC);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, FWD} state_t;
  typedef enum logic [1:0] {M_SCAN, M_1, M_10, M_CHK} mst_t;

  state_t        state;
  mst_t          mst;
  mst_t          mst_nxt;
  logic [SW-1:0] grant;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic          found;
  logic          first;
  logic          tag_start;
  logic [7:0]    sum;
  logic [7:0]    chk_base;
  logic [9:0]    val;
  logic [9:0]    val_sat;
  logic [13:0]   val_mul;
  logic [2:0]    cnt;
  logic          bad;
  logic [IW-1:0] idle_cnt;

  logic [7:0]    cur_byte;
  logic          accept;
  logic          is_soh;
  logic          is_digit;
  logic          eom;
  logic          timeout_hit;

  assign cur_byte    = src_data_i[{grant, 3'b000} +: 8];
  assign accept      = (state == FWD) && src_valid_i[grant];
  assign is_soh      = (cur_byte == 8'h01);
  assign is_digit    = (cur_byte >= 8'h30) && (cur_byte <= 8'h39);
  assign eom         = accept && is_soh && (mst == M_CHK);
  assign timeout_hit = (state == FWD) && !accept
                       && (idle_cnt == IW'(TIMEOUT - 1));
  assign busy_o      = (state == FWD);

  // ASCII digits carry their value in the low nibble
  assign val_mul = {4'b0000, val} * 14'd10 + {10'b0, cur_byte[3:0]};
  assign val_sat = (val_mul > 14'd1023) ? 10'h3FF : val_mul[9:0];

  always_comb begin
    src_ready_o = '0;
    if (state == FWD) src_ready_o[grant] = 1'b1;
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = SW'((int'(rr_ptr) + i) % N_SRC);
      if (!found && src_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // "10=" only counts when its '1' opens a field
  always_comb begin
    mst_nxt = M_SCAN;
    unique case (1'b1)
      tag_start && (cur_byte == 8'h31):  mst_nxt = M_1;
      (mst == M_1) && (cur_byte == 8'h30): mst_nxt = M_10;
      (mst == M_10) && (cur_byte == 8'h3D): mst_nxt = M_CHK;
      default: mst_nxt = M_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mst          <= M_SCAN;
      grant        <= '0;
      rr_ptr       <= SW'(N_SRC - 1);
      first        <= 1'b0;
      tag_start    <= 1'b0;
      sum          <= '0;
      chk_base     <= '0;
      val          <= '0;
      cnt          <= '0;
      bad          <= 1'b0;
      idle_cnt     <= '0;
      par_data_o   <= '0;
      par_valid_o  <= 1'b0;
      par_sof_o    <= 1'b0;
      par_eof_o    <= 1'b0;
      par_src_o    <= '0;
      msg_done_o   <= 1'b0;
      msg_chk_ok_o <= 1'b0;
      msg_abort_o  <= 1'b0;
    end else begin
      par_valid_o  <= accept;
      par_data_o   <= accept ? cur_byte : 8'h00;
      par_sof_o    <= accept && first;
      par_eof_o    <= eom;
      msg_done_o   <= eom;
      msg_chk_ok_o <= eom && (cnt == 3'd3) && !bad
                      && (val == {2'b00, chk_base});
      msg_abort_o  <= timeout_hit;
      unique case (state)
        IDLE: begin
          if (found) begin
            state     <= FWD;
            grant     <= pick;
            rr_ptr    <= pick;
            par_src_o <= pick;
            first     <= 1'b1;
            tag_start <= 1'b1;
            mst       <= M_SCAN;
            sum       <= '0;
            val       <= '0;
            cnt       <= '0;
            bad       <= 1'b0;
            idle_cnt  <= '0;
          end
        end
        FWD: begin
          if (accept) begin
            first    <= 1'b0;
            idle_cnt <= '0;
            sum      <= sum + cur_byte;
            if (is_soh) begin
              chk_base  <= sum + 8'h01;
              tag_start <= 1'b1;
              mst       <= M_SCAN;
              if (mst == M_CHK) state <= IDLE;
            end else if (mst == M_CHK) begin
              if (is_digit) begin
                val <= val_sat;
                if (cnt != 3'd4) cnt <= cnt + 3'd1;
              end else begin
                bad <= 1'b1;
              end
            end else begin
              tag_start <= 1'b0;
              mst       <= mst_nxt;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
      endcase
    end
  end

endmodule
